// File: rtl/seq_penc_pkg.sv
// rtl/seq_penc_pkg.sv - shared constants and helpers for the sequential priority encoder
package seq_penc_pkg;

  typedef enum logic {
    ST_IDLE = 1'b0,
    ST_SCAN = 1'b1
  } state_t;

  function automatic int clog2(input int v);
    int r;
    for (r = 0; (1 << r) < v; r++) begin
    end
    return r;
  endfunction

endpackage

// File: rtl/penc_find.sv
// rtl/penc_find.sv - combinational first-set-bit finder with any/onehot flags
module penc_find
  import seq_penc_pkg::*;
#(
  parameter int N         = 8,
  parameter bit MSB_FIRST = 1'b1,
  localparam int W        = clog2(N)
) (
  input  logic [N-1:0] vec,
  output logic [W-1:0] idx,
  output logic         any,
  output logic         onehot
);

  localparam logic [N-1:0] ONE = {{(N-1){1'b0}}, 1'b1};

  // The last match written wins, so the loop direction selects the priority order.
  always_comb begin
    idx = '0;
    if (MSB_FIRST) begin
      for (int i = 0; i < N; i++)
        if (vec[i]) idx = W'(i);
    end else begin
      for (int i = N - 1; i >= 0; i--)
        if (vec[i]) idx = W'(i);
    end
  end

  assign any    = |vec;
  assign onehot = any && ((vec & (vec - ONE)) == '0);

endmodule

// File: rtl/seq_priority_encoder.sv
// rtl/seq_priority_encoder.sv - accepts a request vector and emits each set index, one per beat
module seq_priority_encoder
  import seq_penc_pkg::*;
#(
  parameter int N         = 8,
  parameter bit MSB_FIRST = 1'b1,
  localparam int W        = clog2(N)
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         en,
  input  logic         in_valid,
  output logic         in_ready,
  input  logic [N-1:0] din,
  output logic         out_valid,
  input  logic         out_ready,
  output logic [W-1:0] dout,
  output logic         out_last,
  output logic         out_none,
  output logic         busy
);

  localparam logic [N-1:0] ONE = {{(N-1){1'b0}}, 1'b1};

  state_t         state, state_nx;
  logic [N-1:0]   pend, pend_nx;
  logic [W-1:0]   idx;
  logic           any, onehot;

  penc_find #(.N(N), .MSB_FIRST(MSB_FIRST)) u_find (
    .vec    (pend),
    .idx    (idx),
    .any    (any),
    .onehot (onehot)
  );

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state <= ST_IDLE;
      pend  <= '0;
    end else begin
      state <= state_nx;
      pend  <= pend_nx;
    end
  end

  always_comb begin
    state_nx  = state;
    pend_nx   = pend;
    in_ready  = 1'b0;
    out_valid = 1'b0;
    busy      = 1'b0;
    case (state)
      ST_IDLE: begin
        in_ready = en && !rst;
        if (in_valid && en) begin
          pend_nx  = din;
          state_nx = ST_SCAN;
        end
      end
      ST_SCAN: begin
        out_valid = 1'b1;
        busy      = 1'b1;
        if (out_ready) begin
          pend_nx = pend & ~(ONE << idx);
          // A zero vector is a single terminal beat, like a lone set bit.
          if (onehot || !any) state_nx = ST_IDLE;
        end
      end
      default: state_nx = ST_IDLE;
    endcase
  end

  assign dout     = busy ? idx : '0;
  assign out_last = busy && (onehot || !any);
  assign out_none = busy && !any;

endmodule

// File: tb/tb_seq_priority_encoder.sv
// tb/tb_seq_priority_encoder.sv - directed and random checks of seq_priority_encoder
module tb_seq_priority_encoder;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        en  = 1'b1;
  logic        ory = 1'b1;
  logic [3:0]  iv  = '0;
  logic [15:0] din16 = '0;

  logic [3:0]  irdy, ovld, olast, onone, obusy;
  logic [2:0]  dout_a, dout_b;
  logic [3:0]  dout_c;
  logic [0:0]  dout_d;

  int checks = 0;
  int errors = 0;
  int cur = 0;

  logic        o_ready, o_valid, o_last, o_none, o_busy;
  logic [15:0] o_dout;

  always #5 clk = ~clk;

  seq_priority_encoder #(.N(8), .MSB_FIRST(1'b1)) dut_a (
    .clk(clk), .rst(rst), .en(en), .in_valid(iv[0]), .in_ready(irdy[0]), .din(din16[7:0]),
    .out_valid(ovld[0]), .out_ready(ory), .dout(dout_a), .out_last(olast[0]),
    .out_none(onone[0]), .busy(obusy[0]));

  seq_priority_encoder #(.N(8), .MSB_FIRST(1'b0)) dut_b (
    .clk(clk), .rst(rst), .en(en), .in_valid(iv[1]), .in_ready(irdy[1]), .din(din16[7:0]),
    .out_valid(ovld[1]), .out_ready(ory), .dout(dout_b), .out_last(olast[1]),
    .out_none(onone[1]), .busy(obusy[1]));

  seq_priority_encoder #(.N(16), .MSB_FIRST(1'b1)) dut_c (
    .clk(clk), .rst(rst), .en(en), .in_valid(iv[2]), .in_ready(irdy[2]), .din(din16),
    .out_valid(ovld[2]), .out_ready(ory), .dout(dout_c), .out_last(olast[2]),
    .out_none(onone[2]), .busy(obusy[2]));

  seq_priority_encoder #(.N(2), .MSB_FIRST(1'b1)) dut_d (
    .clk(clk), .rst(rst), .en(en), .in_valid(iv[3]), .in_ready(irdy[3]), .din(din16[1:0]),
    .out_valid(ovld[3]), .out_ready(ory), .dout(dout_d), .out_last(olast[3]),
    .out_none(onone[3]), .busy(obusy[3]));

  always_comb begin
    o_ready = irdy[cur];
    o_valid = ovld[cur];
    o_last  = olast[cur];
    o_none  = onone[cur];
    o_busy  = obusy[cur];
    case (cur)
      0:       o_dout = {13'd0, dout_a};
      1:       o_dout = {13'd0, dout_b};
      2:       o_dout = {12'd0, dout_c};
      default: o_dout = {15'd0, dout_d};
    endcase
  end

  task automatic chk(input string tag, input int obs, input int exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s dut=%0d observed=%0d expected=%0d", tag, cur, obs, exp);
    end
  endtask

  function automatic int width_of(input int sel);
    case (sel)
      0, 1:    return 8;
      2:       return 16;
      default: return 2;
    endcase
  endfunction

  // Reference: list the set positions, then order them by the instance's priority direction.
  task automatic send(input logic [15:0] v, input int sel, input bit stall);
    int q[$];
    int n;
    logic [15:0] held;
    n = width_of(sel);
    for (int i = 0; i < n; i++) if (v[i]) q.push_back(i);
    if (sel != 1) q.reverse();
    cur = sel;
    din16 = v;
    iv = 4'b0001 << sel;
    #1;
    chk("in_ready_idle", int'(o_ready), 1);
    chk("valid_before_accept", int'(o_valid), 0);
    @(posedge clk);
    @(negedge clk);
    iv = '0;
    if (q.size() == 0) begin
      chk("zero_valid", int'(o_valid), 1);
      chk("zero_dout", int'(o_dout), 0);
      chk("zero_none", int'(o_none), 1);
      chk("zero_last", int'(o_last), 1);
      @(posedge clk);
      @(negedge clk);
    end
    for (int k = 0; k < q.size(); k++) begin
      if (stall && k == 0) begin
        ory = 1'b0;
        held = o_dout;
        repeat (3) begin
          @(posedge clk);
          @(negedge clk);
          din16 = 16'($urandom);
          #1;
          chk("stall_valid", int'(o_valid), 1);
          chk("stall_dout", int'(o_dout), int'(held));
        end
        ory = 1'b1;
      end
      chk("beat_valid", int'(o_valid), 1);
      chk("beat_busy", int'(o_busy), 1);
      chk("beat_ready", int'(o_ready), 0);
      chk("beat_dout", int'(o_dout), q[k]);
      chk("beat_last", int'(o_last), (k == q.size() - 1) ? 1 : 0);
      chk("beat_none", int'(o_none), 0);
      @(posedge clk);
      @(negedge clk);
      din16 = 16'($urandom);
    end
    #1;
    chk("gap_valid", int'(o_valid), 0);
    chk("gap_busy", int'(o_busy), 0);
  endtask

  initial begin
    #1;
    chk("rst_valid", int'(o_valid), 0);
    chk("rst_ready", int'(o_ready), 0);
    chk("rst_dout", int'(o_dout), 0);
    chk("rst_last", int'(o_last), 0);
    chk("rst_none", int'(o_none), 0);
    chk("rst_busy", int'(o_busy), 0);
    repeat (2) @(posedge clk);
    @(negedge clk);
    rst = 1'b0;

    for (int i = 0; i < 8; i++) send(16'(1 << i), 0, 1'b0);

    en = 1'b0;
    din16 = 16'h0055;
    iv = 4'b0001;
    repeat (3) begin
      @(posedge clk);
      @(negedge clk);
      chk("en_low_ready", int'(o_ready), 0);
      chk("en_low_valid", int'(o_valid), 0);
    end
    en = 1'b1;
    send(16'h0055, 0, 1'b0);

    send(16'h00A6, 0, 1'b0);
    send(16'h00A6, 1, 1'b0);
    send(16'h0000, 0, 1'b0);
    send(16'h0012, 0, 1'b1);
    send(16'h00FF, 0, 1'b0);

    cur = 0;
    din16 = 16'h00FF;
    iv = 4'b0001;
    @(posedge clk);
    @(negedge clk);
    iv = '0;
    chk("pre_rst_beat0", int'(o_dout), 7);
    @(posedge clk);
    @(negedge clk);
    chk("pre_rst_beat1", int'(o_dout), 6);
    @(posedge clk);
    @(negedge clk);
    rst = 1'b1;
    #1;
    chk("mid_rst_valid", int'(o_valid), 0);
    chk("mid_rst_dout", int'(o_dout), 0);
    chk("mid_rst_busy", int'(o_busy), 0);
    chk("mid_rst_ready", int'(o_ready), 0);
    @(posedge clk);
    @(negedge clk);
    rst = 1'b0;
    send(16'h0001, 0, 1'b0);

    send(16'h8001, 2, 1'b0);
    send(16'h0003, 3, 1'b0);

    for (int r = 0; r < 24; r++) begin
      logic [15:0] v;
      int sel;
      sel = int'($urandom_range(0, 3));
      v = 16'($urandom);
      if ($urandom_range(0, 5) == 0) v = '0;
      send(v, sel, $urandom_range(0, 3) == 0);
    end

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

// File: doc/seq_priority_encoder.md
Name: seq_priority_encoder

Overview:
Parametrised, clocked successor to the team's 8-to-3 enabled encoder. Accepts an N-bit request vector over a valid/ready handshake. Emits the index of every set bit, one per output beat, in priority order, with a last flag and a no-hit flag. Sits between request-collection logic (interrupt or request lines) and any serial consumer that services one index at a time.

Parameters:
N, 8, input vector width; legal range 2..256.
MSB_FIRST, 1, scan order: 1 emits the highest set index first (classic priority encoder); 0 emits the lowest first.
W, $clog2(N), output index width; derived, never overridden.

Ports:
clk  input  1  rising-edge clock
rst  input  1  asynchronous, active-high reset
en  input  1  acceptance enable; low blocks new vectors only
in_valid  input  1  din is valid
in_ready  output  1  block can accept a vector
din  input  N  request vector
out_valid  output  1  dout, out_last and out_none are valid
out_ready  input  1  consumer takes the current beat
dout  output  W  index of the current set bit
out_last  output  1  current beat is the final one for this vector
out_none  output  1  vector was all zeros; dout is 0
busy  output  1  a vector is held (state SCAN)

Behaviour:
- Reset (async assert, sync-safe deassert):
  - state=IDLE; pend register cleared.
  - out_valid=0, dout=0, out_last=0, out_none=0, busy=0, in_ready=0 while rst is high.
- State machine has two states, IDLE and SCAN.
  - IDLE: in_ready = en. An accept is in_valid && in_ready. On accept, pend <= din and state <= SCAN.
  - SCAN: in_ready=0, busy=1, out_valid=1.
- Output latency: out_valid rises the cycle after accept. Outputs are decoded from pend each cycle (the find is combinational on pend), so no extra bubble.
- Non-zero pend:
  - dout = first set index of pend in the MSB_FIRST order.
  - out_last = 1 when pend has exactly one bit set.
  - out_none = 0.
- Zero vector accepted: exactly one beat with dout=0, out_none=1, out_last=1.
- Output handshake is out_valid && out_ready.
  - On handshake, clear the emitted bit in pend.
  - If the beat was last, go to IDLE. out_valid=0 and in_ready=en in the next cycle, so there is one idle cycle between vectors.
  - Otherwise stay in SCAN; the next index is presented in the next cycle. Throughput is one index per cycle under continuous out_ready.
- Stall: while out_valid && !out_ready, dout, out_last and out_none are held stable and pend is unchanged.
- en:
  - Sampled only in IDLE.
  - Dropping en during SCAN does not abort; the vector drains fully.
  - Raising en in IDLE permits acceptance in that same cycle.
- din changes while in SCAN are ignored; only the captured pend is used.
- All-ones vector with N=8, MSB_FIRST=1 gives beats 7,6,5,4,3,2,1,0, with out_last on index 0.
- Reset mid-SCAN: pend is discarded, outputs return to reset values immediately, and no partial beat is emitted.
- Out-of-order or duplicate indices are never legal; each set bit is emitted exactly once.

Decomposition:
- Package seq_penc_pkg:
  - clog2 constant function.
  - State encoding localparams ST_IDLE and ST_SCAN.
- One sub-module, penc_find (parameters N and MSB_FIRST), purely combinational. Input vec[N-1:0]. Outputs:
  - idx[W-1:0], the first set index in order;
  - any, the OR of vec;
  - onehot, set when exactly one bit of vec is set.
- The top-level holds the FSM, the pend register and the handshake logic.

Test Plan:
- Walking one-hot, N=8, MSB_FIRST=1, out_ready=1. din=8'b00000001..8'b10000000 with en=1 gives one beat each, dout=0..7, out_last=1, out_none=0. Repeat with en=0: in_ready=0 and no beats.
- Multi-hit: din=8'b10100110, MSB_FIRST=1 gives beats 7,5,2,1 on consecutive cycles, out_last only on 1. Same din with MSB_FIRST=0 gives 1,2,5,7.
- Zero vector: din=8'h00 gives a single beat with dout=0, out_none=1, out_last=1, then IDLE.
- Backpressure: din=8'b00010010 with out_ready low for 3 cycles on the first beat. dout=4 is held stable for 3 cycles, then beats 4 and 1 follow. Toggling din during SCAN has no effect.
- Reset mid-scan: din=8'hFF, assert rst after the second beat. Outputs are 0 immediately. After deassert, the next vector 8'h01 gives a single beat with dout=0.
- Width scaling: N=16, din=16'h8001 gives beats 15 then 0 (W=4). Also N=2 sanity: din=2'b11 gives beats 1 then 0.
